// File: rtl/branch_commit_queue_pkg.sv
// Shared widths and the per-entry record for the branch commit queue.
package branch_commit_queue_pkg;
  localparam int XLEN              = 32;
  localparam int BQ_SIZE_WIDTH_DEF = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred;
    logic [XLEN-1:0] alt_target;
    logic            jump;
  } bq_entry_t;
endpackage

// File: rtl/branch_commit_queue.sv
// In-order queue of in-flight branches; drives predictor update and redirect at commit.
// Optional statistics counters under BQ_STATS_EN.
module branch_commit_queue
  import branch_commit_queue_pkg::*;
#(
  parameter int BQ_SIZE_WIDTH = BQ_SIZE_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     dec_bq_valid,
  input  logic [XLEN-1:0]          dec_bq_pc,
  input  logic                     dec_bq_pred,
  input  logic [XLEN-1:0]          dec_bq_alt_target,
  output logic                     bq_full,
  output logic [BQ_SIZE_WIDTH-1:0] bq_alloc_tag,
  input  logic                     alu_bq_valid,
  input  logic [BQ_SIZE_WIDTH-1:0] alu_bq_tag,
  input  logic                     alu_bq_jump,
  output logic                     bq_head_ready,
  input  logic                     rob_bq_commit,
  output logic                     bq_bp_enable,
  output logic [XLEN-1:0]          bq_bp_inst_addr,
  output logic                     bq_bp_jump,
  output logic                     bq_bp_correct,
  output logic                     bq_mispredict,
  output logic [XLEN-1:0]          bq_redirect_pc
`ifdef BQ_STATS_EN
  ,
  output logic [XLEN-1:0]          bq_commit_cnt,
  output logic [XLEN-1:0]          bq_mispred_cnt
`endif
);
  localparam int DEPTH = 1 << BQ_SIZE_WIDTH;
  localparam logic [BQ_SIZE_WIDTH:0] FULL_CNT = (BQ_SIZE_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]         valid, resolved;
  bq_entry_t                ent [DEPTH];
  logic [BQ_SIZE_WIDTH-1:0] head, tail;
  logic [BQ_SIZE_WIDTH:0]   count;
  bq_entry_t                head_ent;
  logic                     do_alloc, do_resolve, do_commit, head_correct;

  assign bq_full       = (count == FULL_CNT);
  assign bq_alloc_tag  = tail;
  assign bq_head_ready = valid[head] && resolved[head];
  assign head_ent      = ent[head];
  assign head_correct  = (head_ent.pred == head_ent.jump);
  // A full queue drops the alloc even if the head retires this cycle.
  assign do_alloc      = dec_bq_valid && !bq_full;
  assign do_resolve    = alu_bq_valid && valid[alu_bq_tag];
  assign do_commit     = rob_bq_commit && bq_head_ready;

  // Payload needs no reset: valid/resolved gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      if (do_alloc)
        ent[tail] <= '{pc: dec_bq_pc, pred: dec_bq_pred,
                       alt_target: dec_bq_alt_target, jump: 1'b0};
      if (do_resolve) ent[alu_bq_tag].jump <= alu_bq_jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid           <= '0;
      resolved        <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      bq_bp_enable    <= 1'b0;
      bq_bp_inst_addr <= '0;
      bq_bp_jump      <= 1'b0;
      bq_bp_correct   <= 1'b0;
      bq_mispredict   <= 1'b0;
      bq_redirect_pc  <= '0;
    end else if (rdy) begin
      if (flush) begin
        valid           <= '0;
        resolved        <= '0;
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        bq_bp_enable    <= 1'b0;
        bq_bp_inst_addr <= '0;
        bq_bp_jump      <= 1'b0;
        bq_bp_correct   <= 1'b0;
        bq_mispredict   <= 1'b0;
        bq_redirect_pc  <= '0;
      end else begin
        if (do_resolve) resolved[alu_bq_tag] <= 1'b1;
        if (do_commit) begin
          valid[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        if (do_alloc) begin
          valid[tail]    <= 1'b1;
          resolved[tail] <= 1'b0;
          tail           <= tail + 1'b1;
        end
        case ({do_alloc, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        bq_bp_enable    <= do_commit;
        bq_bp_inst_addr <= do_commit ? head_ent.pc : '0;
        bq_bp_jump      <= do_commit && head_ent.jump;
        bq_bp_correct   <= do_commit && head_correct;
        bq_mispredict   <= do_commit && !head_correct;
        bq_redirect_pc  <= (do_commit && !head_correct) ? head_ent.alt_target : '0;
      end
    end
  end

`ifdef BQ_STATS_EN
  // Counters survive flush so they reflect lifetime totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bq_commit_cnt  <= '0;
      bq_mispred_cnt <= '0;
    end else if (rdy && !flush && do_commit) begin
      bq_commit_cnt <= bq_commit_cnt + 1'b1;
      if (!head_correct) bq_mispred_cnt <= bq_mispred_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_commit_queue.sv
// Directed plus random stimulus for branch_commit_queue against a queue-based model.
module tb_branch_commit_queue;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic        dec_bq_valid = 1'b0, dec_bq_pred = 1'b0;
  logic [31:0] dec_bq_pc = '0, dec_bq_alt_target = '0;
  logic        bq_full, bq_head_ready;
  logic [2:0]  bq_alloc_tag;
  logic        alu_bq_valid = 1'b0, alu_bq_jump = 1'b0;
  logic [2:0]  alu_bq_tag = '0;
  logic        rob_bq_commit = 1'b0;
  logic        bq_bp_enable, bq_bp_jump, bq_bp_correct, bq_mispredict;
  logic [31:0] bq_bp_inst_addr, bq_redirect_pc;
`ifdef BQ_STATS_EN
  logic [31:0] bq_commit_cnt, bq_mispred_cnt;
`endif

  int checks = 0, failures = 0;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] alt;
    logic        res;
    logic        j;
  } m_t;
  m_t q[$];
  int next_tag = 0;
  logic        e_en = 0, e_j = 0, e_cor = 0, e_mis = 0;
  logic [31:0] e_pc = 0, e_red = 0, e_cc = 0, e_mc = 0;

  always #5 clk = ~clk;

  branch_commit_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dec_bq_valid(dec_bq_valid), .dec_bq_pc(dec_bq_pc), .dec_bq_pred(dec_bq_pred),
    .dec_bq_alt_target(dec_bq_alt_target), .bq_full(bq_full), .bq_alloc_tag(bq_alloc_tag),
    .alu_bq_valid(alu_bq_valid), .alu_bq_tag(alu_bq_tag), .alu_bq_jump(alu_bq_jump),
    .bq_head_ready(bq_head_ready), .rob_bq_commit(rob_bq_commit),
    .bq_bp_enable(bq_bp_enable), .bq_bp_inst_addr(bq_bp_inst_addr), .bq_bp_jump(bq_bp_jump),
    .bq_bp_correct(bq_bp_correct), .bq_mispredict(bq_mispredict),
    .bq_redirect_pc(bq_redirect_pc)
`ifdef BQ_STATS_EN
    , .bq_commit_cnt(bq_commit_cnt), .bq_mispred_cnt(bq_mispred_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, o, e);
    end
  endtask

  task automatic check_all();
    chk("full", {31'b0, bq_full}, {31'b0, q.size() == 8});
    chk("alloc_tag", {29'b0, bq_alloc_tag}, next_tag);
    chk("head_ready", {31'b0, bq_head_ready}, {31'b0, q.size() > 0 && q[0].res});
    chk("bp_enable", {31'b0, bq_bp_enable}, {31'b0, e_en});
    chk("mispredict", {31'b0, bq_mispredict}, {31'b0, e_mis});
    if (e_en) begin
      chk("inst_addr", bq_bp_inst_addr, e_pc);
      chk("bp_jump", {31'b0, bq_bp_jump}, {31'b0, e_j});
      chk("bp_correct", {31'b0, bq_bp_correct}, {31'b0, e_cor});
      if (e_mis) chk("redirect_pc", bq_redirect_pc, e_red);
    end
`ifdef BQ_STATS_EN
    chk("commit_cnt", bq_commit_cnt, e_cc);
    chk("mispred_cnt", bq_mispred_cnt, e_mc);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    next_tag = 0;
    {e_en, e_j, e_cor, e_mis} = '0;
    e_pc = 0; e_red = 0; e_cc = 0; e_mc = 0;
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input logic fl, input logic dv, input logic [31:0] pc, input logic pd,
                      input logic [31:0] alt, input logic av, input logic [2:0] at,
                      input logic aj, input logic cm, input logic r = 1'b1);
    m_t  e, n;
    bit  hr, full;
    flush = fl; dec_bq_valid = dv; dec_bq_pc = pc; dec_bq_pred = pd;
    dec_bq_alt_target = alt; alu_bq_valid = av; alu_bq_tag = at; alu_bq_jump = aj;
    rob_bq_commit = cm; rdy = r;
    if (r) begin
      if (fl) begin
        q.delete();
        next_tag = 0;
        {e_en, e_j, e_cor, e_mis} = '0;
      end else begin
        full = (q.size() == 8);
        hr   = (q.size() > 0) && q[0].res;
        if (cm && hr) e = q[0];
        if (av) foreach (q[i]) if (q[i].tag == int'(at)) begin q[i].res = 1; q[i].j = aj; end
        if (cm && hr) begin
          void'(q.pop_front());
          e_en = 1; e_pc = e.pc; e_j = e.j; e_cor = (e.pred == e.j); e_mis = !e_cor;
          e_red = e.alt;
          e_cc++;
          if (e_mis) e_mc++;
        end else {e_en, e_j, e_cor, e_mis} = '0;
        if (dv && !full) begin
          n = '{tag: next_tag, pc: pc, pred: pd, alt: alt, res: 1'b0, j: 1'b0};
          q.push_back(n);
          next_tag = (next_tag + 1) % 8;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alloc(input logic [31:0] pc, input logic pd, input logic [31:0] alt);
    step(0, 1, pc, pd, alt, 0, 0, 0, 0);
  endtask
  task automatic resolve(input logic [2:0] t, input logic j);
    step(0, 0, 0, 0, 0, 1, t, j, 0);
  endtask
  task automatic commit();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic do_flush();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check_all();

    // correctly predicted taken branch
    alloc(32'h100, 1, 32'h104);
    resolve(0, 1);
    commit();
    chk("t1_enable", {31'b0, bq_bp_enable}, 32'd1);
    chk("t1_addr", bq_bp_inst_addr, 32'h100);
    idle();

    // mispredicted branch, one-cycle pulse
    alloc(32'h200, 0, 32'h240);
    resolve(1, 1);
    commit();
    chk("t2_redirect", bq_redirect_pc, 32'h240);
    idle();
    chk("t2_pulse_gone", {31'b0, bq_mispredict}, 32'd0);

    // fill, drop 9th, commit+alloc while full
    do_flush();
    for (int i = 0; i < 8; i++) alloc(32'h1000 + 32'(i) * 4, i[0], 32'h2000 + 32'(i));
    chk("t3_full", {31'b0, bq_full}, 32'd1);
    alloc(32'hdead, 1, 32'hbeef);
    chk("t3_tail_wrap", {29'b0, bq_alloc_tag}, 32'd0);
    resolve(0, 0);
    step(0, 1, 32'hcafe, 0, 32'h1, 0, 0, 0, 1);
    chk("t3_not_full", {31'b0, bq_full}, 32'd0);
    alloc(32'h3000, 0, 32'h3004);
    chk("t3_full_again", {31'b0, bq_full}, 32'd1);

    // out-of-order resolve does not let a younger entry retire
    do_flush();
    alloc(32'h400, 1, 32'h500);
    alloc(32'h410, 1, 32'h510);
    resolve(1, 1);
    commit();
    chk("t4_ignored", {31'b0, bq_bp_enable}, 32'd0);
    resolve(0, 0);
    commit();
    chk("t4_head_first", bq_bp_inst_addr, 32'h400);
    commit();

    // resolve of head coinciding with commit does not satisfy it
    alloc(32'h600, 0, 32'h700);
    step(0, 0, 0, 0, 0, 1, 2, 0, 1);
    commit();

    // rdy low holds everything
    alloc(32'h800, 1, 32'h900);
    resolve(3, 1);
    step(0, 1, 32'h1, 0, 32'h2, 0, 0, 0, 1, 1'b0);
    commit();

    // flush with entries pending
    do_flush();
    for (int i = 0; i < 5; i++) alloc(32'h5000 + 32'(i), 0, 32'h6000);
    do_flush();
    chk("t5_tag0", {29'b0, bq_alloc_tag}, 32'd0);
    alloc(32'h7000, 0, 32'h7004);

    // stats: 3 commits, 1 mispredict, then flush keeps counters
    do_flush();
    for (int i = 0; i < 3; i++) begin
      alloc(32'h8000 + 32'(i), 1, 32'h9000);
      resolve(3'(i), (i != 1));
      commit();
    end
    do_flush();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 99) < 3), $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
           $urandom, $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 9) != 0));
    end

    // async reset mid-cycle while a pulse is high and entries pending
    do_flush();
    alloc(32'ha00, 0, 32'ha40);
    alloc(32'ha10, 0, 32'ha50);
    resolve(0, 1);
    commit();
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_enable", {31'b0, bq_bp_enable}, 32'd0);
    chk("rst_mispredict", {31'b0, bq_mispredict}, 32'd0);
    chk("rst_redirect", bq_redirect_pc, 32'd0);
    check_all();
    @(negedge clk) rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
